// File: rtl/game_pkg.sv
// Shared game constants: occupancy codes, palette indices, palette colours and playfield size.
package game_pkg;

  localparam int GRID_W     = 16;
  localparam int GRID_H     = 16;
  localparam int GRID_CELLS = GRID_W * GRID_H;

  localparam logic [3:0] OCC_NONE        = 4'd0;
  localparam logic [3:0] OCC_PLAYER      = 4'd1;
  localparam logic [3:0] OCC_BOMB        = 4'd2;
  localparam logic [3:0] OCC_ADD_BOMB    = 4'd3;
  localparam logic [3:0] OCC_CEN         = 4'd4;
  localparam logic [3:0] OCC_FIRE_H      = 4'd5;
  localparam logic [3:0] OCC_FIRE_V      = 4'd6;
  localparam logic [3:0] OCC_FIRE_X      = 4'd7;
  localparam logic [3:0] OCC_BRICK       = 4'd8;
  localparam logic [3:0] OCC_WALL        = 4'd9;
  localparam logic [3:0] OCC_PWR_BOMB    = 4'd10;
  localparam logic [3:0] OCC_PWR_FIRE    = 4'd11;
  localparam logic [3:0] OCC_PWR_SPEED   = 4'd12;
  localparam logic [3:0] OCC_ILLEGAL_MIN = 4'd13;

  localparam logic [3:0] PAL_BLACK     = 4'd0;
  localparam logic [3:0] PAL_FLOOR     = 4'd1;
  localparam logic [3:0] PAL_WALL      = 4'd2;
  localparam logic [3:0] PAL_WALL_EDGE = 4'd3;
  localparam logic [3:0] PAL_BRICK     = 4'd4;
  localparam logic [3:0] PAL_BOMB      = 4'd5;
  localparam logic [3:0] PAL_FUSE      = 4'd6;
  localparam logic [3:0] PAL_FIRE      = 4'd7;
  localparam logic [3:0] PAL_PLAYER    = 4'd8;
  localparam logic [3:0] PAL_CENTER    = 4'd9;
  localparam logic [3:0] PAL_ADD       = 4'd10;
  localparam logic [3:0] PAL_PWR       = 4'd11;
  localparam logic [3:0] PAL_SKIN      = 4'd12;

  localparam logic [23:0] PALETTE_RGB [0:15] = '{
    24'h000000, 24'h1E6E1E, 24'h808080, 24'hC0C0C0,
    24'hB04020, 24'h101010, 24'hFF8000, 24'hFFD000,
    24'h2040FF, 24'hFF2000, 24'hFFFFFF, 24'h00C0FF,
    24'hFFC080, 24'h000000, 24'h000000, 24'h000000
  };

  localparam logic [23:0] RGB_MAGENTA   = 24'hFF00FF;
  localparam logic [23:0] RGB_GRID_LINE = 24'h404040;

  typedef enum logic {WAIT_FRAME, RUN} render_state_t;

  function automatic logic [23:0] palette_rgb(input logic [3:0] idx);
    return PALETTE_RGB[idx];
  endfunction

endpackage

// File: rtl/occ_sprite_rom.sv
// 4096x4 sprite ROM: address {code, sub_y, sub_x} to palette index, one registered cycle.
module occ_sprite_rom
  import game_pkg::*;
(
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [3:0]  pal_idx
);

  // Each 16x16 sprite is described procedurally; synthesis folds it into a constant table.
  function automatic logic [3:0] sprite_texel(input logic [3:0] code,
                                              input logic [3:0] sy,
                                              input logic [3:0] sx);
    logic border;
    logic band_x;
    logic band_y;
    logic bomb_body;
    int   cx;
    int   cy;
    cx        = int'(sx) - 8;
    cy        = int'(sy) - 8;
    bomb_body = (cx * cx + cy * cy) < 36;
    border    = (sx == 4'd0) || (sx == 4'd15) || (sy == 4'd0) || (sy == 4'd15);
    band_x    = (sx >= 4'd5) && (sx <= 4'd10);
    band_y    = (sy >= 4'd5) && (sy <= 4'd10);
    case (code)
      OCC_NONE:      sprite_texel = PAL_FLOOR;
      OCC_PLAYER:    sprite_texel = ((sx >= 4'd4) && (sx <= 4'd11) && (sy >= 4'd2) && (sy <= 4'd13))
                                    ? ((sy < 4'd5) ? PAL_SKIN : PAL_PLAYER) : PAL_FLOOR;
      OCC_BOMB:      sprite_texel = bomb_body ? PAL_BOMB
                                    : ((sx == 4'd8) && (sy < 4'd3)) ? PAL_FUSE : PAL_BLACK;
      OCC_ADD_BOMB:  sprite_texel = (sx[0] ^ sy[0]) ? PAL_ADD : PAL_FLOOR;
      OCC_CEN:       sprite_texel = (((sx >= 4'd2) && (sx <= 4'd13)) || ((sy >= 4'd2) && (sy <= 4'd13)))
                                    ? PAL_CENTER : PAL_FIRE;
      OCC_FIRE_H:    sprite_texel = band_y ? PAL_FIRE : PAL_FLOOR;
      OCC_FIRE_V:    sprite_texel = band_x ? PAL_FIRE : PAL_FLOOR;
      OCC_FIRE_X:    sprite_texel = (band_x || band_y) ? PAL_FIRE : PAL_FLOOR;
      OCC_BRICK:     sprite_texel = (sy[1:0] == 2'd0) ? PAL_WALL_EDGE : PAL_BRICK;
      OCC_WALL:      sprite_texel = border ? PAL_WALL_EDGE : PAL_WALL;
      OCC_PWR_BOMB:  sprite_texel = border ? PAL_PWR : PAL_BOMB;
      OCC_PWR_FIRE:  sprite_texel = border ? PAL_PWR : PAL_FIRE;
      OCC_PWR_SPEED: sprite_texel = border ? PAL_PWR : PAL_PLAYER;
      default:       sprite_texel = PAL_BLACK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    pal_idx <= sprite_texel(addr[11:8], addr[7:4], addr[3:0]);
  end

endmodule

// File: rtl/occ_tile_renderer.sv
// Occupancy grid to RGB renderer: frame snapshot, then coordinate->cell, sprite ROM, palette stages.
// Build macro GRID_LINES_EN overlays tile grid lines (sub_x or sub_y zero) inside the playfield.
module occ_tile_renderer
  import game_pkg::*;
#(
  parameter int          ORIGIN_X  = 192,
  parameter int          ORIGIN_Y  = 112,
  parameter int          TILE_LOG2 = 4,
  parameter logic [23:0] BG_RGB    = 24'h202020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  occ_grid [0:GRID_CELLS-1],
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  output logic        in_field
);

  localparam int FIELD_PX = GRID_W << TILE_LOG2;

  render_state_t state;
  logic [3:0]    snapshot [0:GRID_CELLS-1];

  // Snapshot writes use non-blocking assignment, so a same-cycle stage-1 read sees the old frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_FRAME;
      for (int i = 0; i < GRID_CELLS; i++) snapshot[i] <= OCC_NONE;
    end else begin
      case (state)
        WAIT_FRAME: if (frame_start) state <= RUN;
        RUN:        state <= RUN;
        default:    state <= WAIT_FRAME;
      endcase
      if (frame_start) begin
        for (int i = 0; i < GRID_CELLS; i++) snapshot[i] <= occ_grid[i];
      end
    end
  end

  logic [10:0] dx;
  logic [10:0] dy;
  logic        field_hit;
  logic [7:0]  cell_idx;

  // Coordinates left of / above the origin wrap to large values and fail the range test.
  assign dx        = {1'b0, pix_x} - 11'(ORIGIN_X);
  assign dy        = {1'b0, pix_y} - 11'(ORIGIN_Y);
  assign field_hit = (dx < 11'(FIELD_PX)) && (dy < 11'(FIELD_PX)) && (state == RUN);
  assign cell_idx  = {dy[TILE_LOG2 +: 4], dx[TILE_LOG2 +: 4]};

  logic       s1_valid;
  logic       s1_in_field;
  logic [3:0] s1_code;
  logic [3:0] s1_sub_x;
  logic [3:0] s1_sub_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_in_field <= 1'b0;
      s1_code     <= OCC_NONE;
      s1_sub_x    <= 4'd0;
      s1_sub_y    <= 4'd0;
    end else begin
      s1_valid    <= pix_valid;
      s1_in_field <= field_hit;
      s1_code     <= field_hit ? snapshot[cell_idx] : OCC_NONE;
      s1_sub_x    <= dx[TILE_LOG2-1 -: 4];
      s1_sub_y    <= dy[TILE_LOG2-1 -: 4];
    end
  end

  logic [3:0] s2_pal;

  occ_sprite_rom u_sprite_rom (
    .clk     (clk),
    .addr    ({s1_code, s1_sub_y, s1_sub_x}),
    .pal_idx (s2_pal)
  );

  logic       s2_valid;
  logic       s2_in_field;
  logic [3:0] s2_code;
`ifdef GRID_LINES_EN
  logic       s2_grid_line;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid     <= 1'b0;
      s2_in_field  <= 1'b0;
      s2_code      <= OCC_NONE;
`ifdef GRID_LINES_EN
      s2_grid_line <= 1'b0;
`endif
    end else begin
      s2_valid     <= s1_valid;
      s2_in_field  <= s1_in_field;
      s2_code      <= s1_code;
`ifdef GRID_LINES_EN
      s2_grid_line <= (s1_sub_x == 4'd0) || (s1_sub_y == 4'd0);
`endif
    end
  end

  logic [23:0] pixel_rgb;

  // Illegal codes paint the whole tile magenta, ahead of any overlay or sprite colour.
  always_comb begin
    pixel_rgb = BG_RGB;
    if (s2_in_field) begin
      if (s2_code >= OCC_ILLEGAL_MIN) pixel_rgb = RGB_MAGENTA;
`ifdef GRID_LINES_EN
      else if (s2_grid_line)          pixel_rgb = RGB_GRID_LINE;
`endif
      else                            pixel_rgb = palette_rgb(s2_pal);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out   <= BG_RGB;
      rgb_valid <= 1'b0;
      in_field  <= 1'b0;
    end else begin
      rgb_valid <= s2_valid;
      if (s2_valid) begin
        rgb_out  <= pixel_rgb;
        in_field <= s2_in_field;
      end
    end
  end

endmodule

// File: tb/tb_occ_tile_renderer.sv
// Directed bench for occ_tile_renderer with hand-computed sprite colours (default build).
module tb_occ_tile_renderer;

  localparam logic [23:0] C_BG        = 24'h202020;
  localparam logic [23:0] C_FLOOR     = 24'h1E6E1E;
  localparam logic [23:0] C_FIRE      = 24'hFFD000;
  localparam logic [23:0] C_CENTER    = 24'hFF2000;
  localparam logic [23:0] C_WALL      = 24'h808080;
  localparam logic [23:0] C_WALL_EDGE = 24'hC0C0C0;
  localparam logic [23:0] C_BLACK     = 24'h000000;
  localparam logic [23:0] C_BOMB      = 24'h101010;
  localparam logic [23:0] C_ADD       = 24'hFFFFFF;
  localparam logic [23:0] C_MAGENTA   = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  occ_grid [0:255];
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic        in_field;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  occ_tile_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .occ_grid    (occ_grid),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .in_field    (in_field)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One isolated pixel: output must be absent at +2 and present at exactly +3 cycles.
  task automatic applyStimulus(input string tag, input int x, input int y, input logic fs,
                               input logic [23:0] exp_rgb, input logic exp_in);
    @(negedge clk);
    pix_valid   = 1'b1;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    frame_start = fs;
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    checkOutput({tag, " early"}, 32'(rgb_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, " valid"}, 32'(rgb_valid), 32'd1);
    checkOutput({tag, " rgb"}, 32'(rgb_out), 32'(exp_rgb));
    checkOutput({tag, " in_field"}, 32'(in_field), 32'(exp_in));
  endtask

  task automatic pulseFrameStart();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    for (int i = 0; i < 256; i++) occ_grid[i] = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset rgb", 32'(rgb_out), 32'(C_BG));
    checkOutput("reset valid", 32'(rgb_valid), 32'd0);
    checkOutput("reset in_field", 32'(in_field), 32'd0);
    reset = 1'b0;

    applyStimulus("pre-frame origin", 192, 112, 1'b0, C_BG, 1'b0);

    occ_grid[0] = 4'd4;
    pulseFrameStart();
    applyStimulus("cen corner", 192, 112, 1'b0, C_FIRE, 1'b1);
    applyStimulus("cen middle", 200, 120, 1'b0, C_CENTER, 1'b1);
    applyStimulus("left of field", 191, 112, 1'b0, C_BG, 1'b0);

    occ_grid[255] = 4'd9;
    pulseFrameStart();
    applyStimulus("wall last px", 447, 367, 1'b0, C_WALL_EDGE, 1'b1);
    applyStimulus("x past field", 448, 367, 1'b0, C_BG, 1'b0);
    applyStimulus("y past field", 447, 368, 1'b0, C_BG, 1'b0);
    applyStimulus("wall inner", 440, 360, 1'b0, C_WALL, 1'b1);

    occ_grid[17] = 4'd2;
    pulseFrameStart();
    occ_grid[17] = 4'd0;
    applyStimulus("bomb held corner", 208, 128, 1'b0, C_BLACK, 1'b1);
    applyStimulus("bomb held body", 216, 136, 1'b0, C_BOMB, 1'b1);
    pulseFrameStart();
    applyStimulus("bomb cleared", 208, 128, 1'b0, C_FLOOR, 1'b1);

    occ_grid[5] = 4'd14;
    pulseFrameStart();
    applyStimulus("illegal tl", 272, 112, 1'b0, C_MAGENTA, 1'b1);
    applyStimulus("illegal br", 287, 127, 1'b0, C_MAGENTA, 1'b1);

    // Snapshot taken on the same cycle as a pixel: that pixel sees the previous frame.
    occ_grid[0] = 4'd0;
    pulseFrameStart();
    @(negedge clk);
    occ_grid[0] = 4'd3;
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_x       = 10'd192;
    pix_y       = 10'd112;
    @(negedge clk);
    frame_start = 1'b0;
    pix_x       = 10'd193;
    @(negedge clk);
    pix_valid   = 1'b0;
    @(negedge clk);
    checkOutput("rbw old valid", 32'(rgb_valid), 32'd1);
    checkOutput("rbw old rgb", 32'(rgb_out), 32'(C_FLOOR));
    checkOutput("rbw old in_field", 32'(in_field), 32'd1);
    @(negedge clk);
    checkOutput("rbw new valid", 32'(rgb_valid), 32'd1);
    checkOutput("rbw new rgb", 32'(rgb_out), 32'(C_ADD));
    @(negedge clk);
    checkOutput("hold valid low", 32'(rgb_valid), 32'd0);
    checkOutput("hold rgb", 32'(rgb_out), 32'(C_ADD));

    // Reset while the pipeline is full.
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x     = 10'd192;
    pix_y     = 10'd112;
    @(negedge clk);
    pix_x = 10'd193;
    @(negedge clk);
    pix_x = 10'd194;
    @(negedge clk);
    checkOutput("stream valid", 32'(rgb_valid), 32'd1);
    checkOutput("stream rgb", 32'(rgb_out), 32'(C_FLOOR));
    reset = 1'b1;
    pix_x = 10'd195;
    @(negedge clk);
    checkOutput("midreset valid", 32'(rgb_valid), 32'd0);
    checkOutput("midreset rgb", 32'(rgb_out), 32'(C_BG));
    checkOutput("midreset in_field", 32'(in_field), 32'd0);
    reset     = 1'b0;
    pix_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("drain %0d", k), 32'(rgb_valid), 32'd0);
    end

    applyStimulus("post-reset wait", 192, 112, 1'b0, C_BG, 1'b0);
    pulseFrameStart();
    applyStimulus("post-reset run", 193, 112, 1'b0, C_ADD, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
